// File: rtl/btn_debouncer.sv
// Per-button synchroniser, debounce FSM and press/release/long-press pulse generator.
// Optional long-press logic is enabled by defining BTN_DEBOUNCER_LONG_PRESS_EN.
module btn_debouncer #(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 50_000_000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] press_pulse,
  output logic [NUM_BTN-1:0] release_pulse,
  output logic [NUM_BTN-1:0] long_pulse
);

  localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] D_ONE  = 1;
  localparam logic IDLE_LVL = (ACTIVE_LOW != 0);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_PEND   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_PEND = 2'd3
  } state_t;

  if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 2) begin : g_bad_param
    $error("btn_debouncer: DEBOUNCE_CYCLES and LONG_CYCLES must be at least 2");
  end

  logic [NUM_BTN-1:0] sync1;
  logic [NUM_BTN-1:0] sync2;
  logic [NUM_BTN-1:0] p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= {NUM_BTN{IDLE_LVL}};
      sync2 <= {NUM_BTN{IDLE_LVL}};
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
    end
  end

  // p is 1 while the synchronised button reads as pressed
  assign p = sync2 ^ {NUM_BTN{IDLE_LVL}};

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    state_t          state_q;
    state_t          state_nxt;
    logic [DW-1:0]   dcnt_q;
    logic [DW-1:0]   dcnt_nxt;
    logic            level_q;
    logic            level_nxt;
    logic            press_q;
    logic            press_nxt;
    logic            release_q;
    logic            release_nxt;
    logic            long_bit;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q   <= RELEASED;
        dcnt_q    <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        state_q   <= state_nxt;
        dcnt_q    <= dcnt_nxt;
        level_q   <= level_nxt;
        press_q   <= press_nxt;
        release_q <= release_nxt;
      end
    end

    // A revert of the level always takes priority over terminal count
    always_comb begin
      state_nxt   = state_q;
      dcnt_nxt    = dcnt_q;
      level_nxt   = level_q;
      press_nxt   = 1'b0;
      release_nxt = 1'b0;
      case (state_q)
        RELEASED: begin
          if (p[g]) begin
            state_nxt = PRESS_PEND;
            dcnt_nxt  = '0;
          end
        end
        PRESS_PEND: begin
          if (!p[g]) begin
            state_nxt = RELEASED;
            dcnt_nxt  = '0;
          end else if (dcnt_q == D_LAST) begin
            state_nxt = PRESSED;
            dcnt_nxt  = '0;
            level_nxt = 1'b1;
            press_nxt = 1'b1;
          end else begin
            dcnt_nxt = dcnt_q + D_ONE;
          end
        end
        PRESSED: begin
          if (!p[g]) begin
            state_nxt = RELEASE_PEND;
            dcnt_nxt  = '0;
          end
        end
        RELEASE_PEND: begin
          if (p[g]) begin
            state_nxt = PRESSED;
            dcnt_nxt  = '0;
          end else if (dcnt_q == D_LAST) begin
            state_nxt   = RELEASED;
            dcnt_nxt    = '0;
            level_nxt   = 1'b0;
            release_nxt = 1'b1;
          end else begin
            dcnt_nxt = dcnt_q + D_ONE;
          end
        end
        default: begin
          state_nxt = RELEASED;
          dcnt_nxt  = '0;
          level_nxt = 1'b0;
        end
      endcase
    end

`ifdef BTN_DEBOUNCER_LONG_PRESS_EN
    localparam int HW = $clog2(LONG_CYCLES) + 1;
    localparam logic [HW-1:0] H_MAX  = HW'(LONG_CYCLES);
    localparam logic [HW-1:0] H_LAST = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0] H_ONE  = 1;

    logic [HW-1:0] hcnt_q;
    logic [HW-1:0] hcnt_nxt;
    logic          long_q;
    logic          long_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hcnt_q <= '0;
        long_q <= 1'b0;
      end else begin
        hcnt_q <= hcnt_nxt;
        long_q <= long_nxt;
      end
    end

    // Counts only while PRESSED, so it stays frozen through a release bounce
    always_comb begin
      hcnt_nxt = hcnt_q;
      long_nxt = 1'b0;
      if (state_q == PRESSED && hcnt_q != H_MAX) begin
        hcnt_nxt = hcnt_q + H_ONE;
        long_nxt = (hcnt_q == H_LAST);
      end
      if (state_nxt == RELEASED) begin
        hcnt_nxt = '0;
      end
    end

    assign long_bit = long_q;
`else
    assign long_bit = 1'b0;
`endif

    assign btn_level[g]     = level_q;
    assign press_pulse[g]   = press_q;
    assign release_pulse[g] = release_q;
    assign long_pulse[g]    = long_bit;
  end

endmodule
